// File: rtl/counter_frame_receiver.sv
// rtl/counter_frame_receiver.sv - serial count-word deserializer with per-channel shadow registers
//
// Ports:
//   clk            single clock, all inputs sampled on the rising edge
//   reset          synchronous active-high; clears all state and outputs
//   serial_in      serial count data, MSB first
//   sl_in          shift/load strobe; one-cycle pulse marks the start of a word
//   addr_in        channel address, sampled together with sl_in
//   ovf_global_in  global overflow, sampled with the last data bit
//   ovf_rtc_in     RTC-window overflow, sampled with the last data bit
//   rd_sel         host read select for the shadow register file
//   data_out       last completed word (holds until the next valid word)
//   chan_out       channel of data_out
//   data_valid     one-cycle pulse: new word on data_out/chan_out
//   frame_err      one-cycle pulse: frame aborted by a reload or discarded for a bad address
//   busy           high while a word is being shifted in
//   rtc_ovf        sticky RTC overflow, cleared by reset only
//   rd_data        shadow word of channel rd_sel (combinational read)
//   rd_ovf         overflow flag stored with channel rd_sel

module counter_frame_receiver #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        serial_in,
  input  logic                        sl_in,
  input  logic [3:0]                  addr_in,
  input  logic                        ovf_global_in,
  input  logic                        ovf_rtc_in,
  input  logic [$clog2(CHANNELS)-1:0] rd_sel,
  output logic [WIDTH-1:0]            data_out,
  output logic [3:0]                  chan_out,
  output logic                        data_valid,
  output logic                        frame_err,
  output logic                        busy,
  output logic                        rtc_ovf,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [WIDTH-1:0]     shift_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [3:0]           addr_q;
  logic [WIDTH-1:0]     shadow_q [CHANNELS];
  logic [CHANNELS-1:0]  ovf_q;

  logic [WIDTH-1:0]     word_next;
  logic                 addr_ok;
  logic                 last_bit;
  logic                 abort;
  logic                 commit;
  logic                 discard;

  // Word as it stands after this cycle's bit is shifted in; on the last
  // bit this is the complete word.
  assign word_next = {shift_q[WIDTH-2:0], serial_in};
  assign addr_ok   = {28'd0, addr_q} < CHANNELS;

  // ---------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------
  // FSM next state and frame events
  // ---------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    last_bit = 1'b0;
    abort    = 1'b0;
    commit   = 1'b0;
    discard  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sl_in) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sl_in) begin
          // A reload always wins, even on the last-bit cycle: the
          // partial word is thrown away and a new frame starts.
          abort   = 1'b1;
          state_d = SHIFT;
        end else if (bit_cnt_q == LAST_BIT) begin
          last_bit = 1'b1;
          commit   = addr_ok;
          discard  = !addr_ok;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath: shifter, bit counter, output word, shadow file
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      addr_q     <= '0;
      data_out   <= '0;
      chan_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      rtc_ovf    <= 1'b0;
      ovf_q      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      data_valid <= commit;
      frame_err  <= abort | discard;

      if (sl_in) begin
        addr_q    <= addr_in;
        shift_q   <= '0;
        bit_cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        shift_q <= word_next;
        // Hold on the last bit; the next load clears the counter anyway.
        if (!last_bit) begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end

      if (commit) begin
        data_out <= word_next;
        chan_out <= addr_q;
        rtc_ovf  <= rtc_ovf | ovf_rtc_in;
        for (int i = 0; i < CHANNELS; i++) begin
          if (addr_q == 4'(i)) begin
            shadow_q[i] <= word_next;
            ovf_q[i]    <= ovf_global_in;
          end
        end
      end
    end
  end

  assign busy    = (state_q == SHIFT);
  assign rd_data = shadow_q[rd_sel];
  assign rd_ovf  = ovf_q[rd_sel];

endmodule

// File: tb/tb_counter_frame_receiver.sv
// tb/tb_counter_frame_receiver.sv - directed self-checking bench for counter_frame_receiver

module tb_counter_frame_receiver;

  logic        clk;
  logic        reset;
  logic        serial_in;
  logic        sl_in;
  logic [3:0]  addr_in;
  logic        ovf_global_in;
  logic        ovf_rtc_in;
  logic [2:0]  rd_sel;
  logic [15:0] data_out;
  logic [3:0]  chan_out;
  logic        data_valid;
  logic        frame_err;
  logic        busy;
  logic        rtc_ovf;
  logic [15:0] rd_data;
  logic        rd_ovf;

  int checks;
  int failures;
  int valid_count;
  int err_count;

  logic [15:0] exp_shadow [8];
  logic        exp_ovf    [8];

  counter_frame_receiver #(
    .WIDTH    (16),
    .CHANNELS (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .sl_in         (sl_in),
    .addr_in       (addr_in),
    .ovf_global_in (ovf_global_in),
    .ovf_rtc_in    (ovf_rtc_in),
    .rd_sel        (rd_sel),
    .data_out      (data_out),
    .chan_out      (chan_out),
    .data_valid    (data_valid),
    .frame_err     (frame_err),
    .busy          (busy),
    .rtc_ovf       (rtc_ovf),
    .rd_data       (rd_data),
    .rd_ovf        (rd_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (data_valid === 1'b1) valid_count++;
    if (frame_err === 1'b1) err_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] a);
    sl_in   = 1'b1;
    addr_in = a;
    tick();
    sl_in   = 1'b0;
  endtask

  task automatic shift_bits(input logic [15:0] w, input int first, input int last,
                            input logic og, input logic orr);
    for (int i = first; i >= last; i--) begin
      serial_in     = w[i];
      ovf_global_in = (i == 0) ? og : 1'b0;
      ovf_rtc_in    = (i == 0) ? orr : 1'b0;
      tick();
    end
    serial_in     = 1'b0;
    ovf_global_in = 1'b0;
    ovf_rtc_in    = 1'b0;
  endtask

  task automatic run_frame(input logic [3:0] a, input logic [15:0] w,
                           input logic og, input logic orr);
    do_load(a);
    shift_bits(w, 15, 0, og, orr);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (data_out !== 16'h0000) begin failures++; $display("FAIL reset_data_out got=%h exp=0000", data_out); end
    checks++;
    if (chan_out !== 4'h0) begin failures++; $display("FAIL reset_chan_out got=%h exp=0", chan_out); end
    checks++;
    if ({data_valid, frame_err, busy, rtc_ovf} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {data_valid, frame_err, busy, rtc_ovf});
    end
    for (int c = 0; c < 8; c++) begin
      rd_sel = 3'(c);
      #1;
      checks++;
      if ({rd_ovf, rd_data} !== 17'h0) begin
        failures++; $display("FAIL reset_shadow%0d got=%h/%b exp=0000/0", c, rd_data, rd_ovf);
      end
    end
  endtask

  task automatic test_single();
    do_load(4'd3);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_start got=%b exp=1", busy); end
    shift_bits(16'hA5C3, 15, 1, 1'b0, 1'b0);
    checks++;
    if ({busy, data_valid} !== 2'b10) begin
      failures++; $display("FAIL single_before_last got=%b exp=10", {busy, data_valid});
    end
    shift_bits(16'hA5C3, 0, 0, 1'b0, 1'b0);
    checks++;
    if (data_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", data_valid); end
    checks++;
    if (data_out !== 16'hA5C3) begin failures++; $display("FAIL single_data got=%h exp=a5c3", data_out); end
    checks++;
    if (chan_out !== 4'd3) begin failures++; $display("FAIL single_chan got=%h exp=3", chan_out); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    rd_sel = 3'd3;
    #1;
    checks++;
    if ({rd_ovf, rd_data} !== {1'b0, 16'hA5C3}) begin
      failures++; $display("FAIL single_shadow got=%h/%b exp=a5c3/0", rd_data, rd_ovf);
    end
    exp_shadow[3] = 16'hA5C3;
    tick();
    checks++;
    if (data_valid !== 1'b0) begin failures++; $display("FAIL single_valid_pulse got=%b exp=0", data_valid); end
    checks++;
    if (data_out !== 16'hA5C3) begin failures++; $display("FAIL single_hold got=%h exp=a5c3", data_out); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_count;
    for (int ch = 0; ch < 8; ch++) begin
      run_frame(4'(ch), 16'h1000 + 16'(ch), (ch == 5), 1'b0);
      exp_shadow[ch] = 16'h1000 + 16'(ch);
      exp_ovf[ch]    = (ch == 5);
      checks++;
      if ({data_valid, chan_out, data_out} !== {1'b1, 4'(ch), 16'h1000 + 16'(ch)}) begin
        failures++;
        $display("FAIL b2b_frame%0d got=%b/%h/%h exp=1/%h/%h", ch, data_valid, chan_out, data_out,
                 4'(ch), 16'h1000 + 16'(ch));
      end
    end
    tick();
    checks++;
    if (valid_count - v0 !== 8) begin
      failures++; $display("FAIL b2b_pulses got=%0d exp=8", valid_count - v0);
    end
    for (int c = 0; c < 8; c++) begin
      rd_sel = 3'(c);
      #1;
      checks++;
      if ({rd_ovf, rd_data} !== {exp_ovf[c], exp_shadow[c]}) begin
        failures++;
        $display("FAIL b2b_shadow%0d got=%h/%b exp=%h/%b", c, rd_data, rd_ovf, exp_shadow[c], exp_ovf[c]);
      end
    end
  endtask

  task automatic test_abort();
    int v0;
    int e0;
    v0 = valid_count;
    e0 = err_count;
    // Reload on the 8th data bit.
    do_load(4'd2);
    shift_bits(16'hDEAD, 15, 9, 1'b0, 1'b0);
    do_load(4'd6);
    checks++;
    if ({frame_err, data_valid, busy} !== 3'b101) begin
      failures++; $display("FAIL abort_mid_err got=%b exp=101", {frame_err, data_valid, busy});
    end
    shift_bits(16'h0666, 15, 1, 1'b0, 1'b0);
    checks++;
    if (data_valid !== 1'b0) begin failures++; $display("FAIL abort_early_valid got=%b exp=0", data_valid); end
    shift_bits(16'h0666, 0, 0, 1'b0, 1'b0);
    checks++;
    if ({data_valid, chan_out, data_out} !== {1'b1, 4'd6, 16'h0666}) begin
      failures++; $display("FAIL abort_second got=%b/%h/%h exp=1/6/0666", data_valid, chan_out, data_out);
    end
    exp_shadow[6] = 16'h0666;
    exp_ovf[6]    = 1'b0;
    // Reload on the last-bit cycle.
    do_load(4'd1);
    shift_bits(16'hBEEF, 15, 1, 1'b0, 1'b0);
    do_load(4'd4);
    checks++;
    if ({frame_err, data_valid} !== 2'b10) begin
      failures++; $display("FAIL abort_last_err got=%b exp=10", {frame_err, data_valid});
    end
    shift_bits(16'h4444, 15, 0, 1'b0, 1'b0);
    exp_shadow[4] = 16'h4444;
    exp_ovf[4]    = 1'b0;
    checks++;
    if ({data_valid, chan_out, data_out} !== {1'b1, 4'd4, 16'h4444}) begin
      failures++; $display("FAIL abort_last_next got=%b/%h/%h exp=1/4/4444", data_valid, chan_out, data_out);
    end
    tick();
    checks++;
    if (valid_count - v0 !== 2 || err_count - e0 !== 2) begin
      failures++; $display("FAIL abort_counts got=%0d/%0d exp=2/2", valid_count - v0, err_count - e0);
    end
    for (int c = 1; c <= 2; c++) begin
      rd_sel = 3'(c);
      #1;
      checks++;
      if (rd_data !== exp_shadow[c]) begin
        failures++; $display("FAIL abort_shadow%0d got=%h exp=%h", c, rd_data, exp_shadow[c]);
      end
    end
  endtask

  task automatic test_bad_addr();
    int v0;
    v0 = valid_count;
    do_load(4'd9);
    shift_bits(16'hFFFF, 15, 1, 1'b1, 1'b0);
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL bad_early_err got=%b exp=0", frame_err); end
    shift_bits(16'hFFFF, 0, 0, 1'b1, 1'b0);
    checks++;
    if ({frame_err, data_valid} !== 2'b10) begin
      failures++; $display("FAIL bad_err got=%b exp=10", {frame_err, data_valid});
    end
    checks++;
    if ({chan_out, data_out} !== {4'd4, 16'h4444}) begin
      failures++; $display("FAIL bad_hold got=%h/%h exp=4/4444", chan_out, data_out);
    end
    tick();
    checks++;
    if (valid_count !== v0) begin failures++; $display("FAIL bad_valid got=%0d exp=%0d", valid_count, v0); end
    for (int c = 0; c < 8; c++) begin
      rd_sel = 3'(c);
      #1;
      checks++;
      if ({rd_ovf, rd_data} !== {exp_ovf[c], exp_shadow[c]}) begin
        failures++;
        $display("FAIL bad_shadow%0d got=%h/%b exp=%h/%b", c, rd_data, rd_ovf, exp_shadow[c], exp_ovf[c]);
      end
    end
  endtask

  task automatic test_rtc_sticky();
    checks++;
    if (rtc_ovf !== 1'b0) begin failures++; $display("FAIL rtc_initial got=%b exp=0", rtc_ovf); end
    run_frame(4'd0, 16'h00AA, 1'b0, 1'b1);
    exp_shadow[0] = 16'h00AA;
    exp_ovf[0]    = 1'b0;
    checks++;
    if (rtc_ovf !== 1'b1) begin failures++; $display("FAIL rtc_set got=%b exp=1", rtc_ovf); end
    run_frame(4'd1, 16'h0055, 1'b0, 1'b0);
    run_frame(4'd2, 16'h0F0F, 1'b0, 1'b0);
    tick();
    checks++;
    if (rtc_ovf !== 1'b1) begin failures++; $display("FAIL rtc_sticky got=%b exp=1", rtc_ovf); end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    int e0;
    do_load(4'd7);
    shift_bits(16'h1234, 15, 7, 1'b0, 1'b0);
    v0 = valid_count;
    e0 = err_count;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({data_valid, frame_err, busy, rtc_ovf, chan_out, data_out} !== 24'h0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b%b%b%b/%h/%h exp=0000/0/0000",
               data_valid, frame_err, busy, rtc_ovf, chan_out, data_out);
    end
    rd_sel = 3'd5;
    #1;
    checks++;
    if ({rd_ovf, rd_data} !== 17'h0) begin
      failures++; $display("FAIL midreset_shadow got=%h/%b exp=0000/0", rd_data, rd_ovf);
    end
    tick();
    checks++;
    if (valid_count !== v0 || err_count !== e0) begin
      failures++; $display("FAIL midreset_pulses got=%0d/%0d exp=%0d/%0d", valid_count, err_count, v0, e0);
    end
    run_frame(4'd5, 16'h5A5A, 1'b1, 1'b0);
    checks++;
    if ({data_valid, chan_out, data_out} !== {1'b1, 4'd5, 16'h5A5A}) begin
      failures++; $display("FAIL midreset_next got=%b/%h/%h exp=1/5/5a5a", data_valid, chan_out, data_out);
    end
    rd_sel = 3'd5;
    #1;
    checks++;
    if ({rd_ovf, rd_data} !== {1'b1, 16'h5A5A}) begin
      failures++; $display("FAIL midreset_next_shadow got=%h/%b exp=5a5a/1", rd_data, rd_ovf);
    end
    rd_sel = 3'd0;
    #1;
    checks++;
    if ({rd_ovf, rd_data} !== 17'h0) begin
      failures++; $display("FAIL midreset_other_shadow got=%h/%b exp=0000/0", rd_data, rd_ovf);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    valid_count   = 0;
    err_count     = 0;
    reset         = 1'b1;
    serial_in     = 1'b0;
    sl_in         = 1'b0;
    addr_in       = 4'd0;
    ovf_global_in = 1'b0;
    ovf_rtc_in    = 1'b0;
    rd_sel        = 3'd0;
    for (int c = 0; c < 8; c++) begin
      exp_shadow[c] = 16'h0;
      exp_ovf[c]    = 1'b0;
    end

    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_bad_addr();
    test_rtc_sticky();
    test_reset_mid_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_frame_receiver.md
# counter_frame_receiver

Receive-side deserializer for the multi-channel impulse counter's serial readout port. It samples the counter's serial data, shift/load strobe, channel address and overflow lines, and reassembles each serialized count word. Words are stored in a per-channel shadow register file with an overflow flag per channel, so the host-side logic (FPGA bridge or test harness) can read any channel's last count at any time. It sits at the far end of the readout link, clocked from the same clock that shifts the counter's serial output.

## Interface
- WIDTH, 16: bits per serialized count word, MSB first.
- CHANNELS, 8: number of counter channels; valid addresses are 0..CHANNELS-1.
- clk  in  1  single clock; all inputs sampled on rising edge.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- serial_in  in  1  counter serial data.
- sl_in  in  1  shift/load strobe; high for one cycle marks start of a word.
- addr_in  in  4  channel address driven by counter, sampled with sl_in.
- ovf_global_in  in  1  counter global overflow, sampled on last data bit.
- ovf_rtc_in  in  1  RTC-window overflow, sampled on last data bit.
- rd_sel  in  3  host read select for shadow registers.
- data_out  out  WIDTH  last completed word.
- chan_out  out  4  channel of data_out.
- data_valid  out  1  one-cycle pulse: new word on data_out/chan_out.
- frame_err  out  1  one-cycle pulse: frame aborted or discarded.
- busy  out  1  high while a word is being shifted in.
- rtc_ovf  out  1  sticky; set when ovf_rtc_in seen at word end, cleared by reset only.
- rd_data  out  WIDTH  shadow register of channel rd_sel (combinational read).
- rd_ovf  out  1  overflow flag stored with channel rd_sel.

## Operation
- States: IDLE, SHIFT. Reset -> IDLE; every output, shift register, bit counter, shadow register and flag = 0.
- IDLE: sl_in=1 -> latch addr_in, clear shift register, bit counter=0, go SHIFT, busy=1 next cycle.
- SHIFT: each cycle shift register <= {shift[WIDTH-2:0], serial_in}, bit counter += 1.
  - Counter reaches WIDTH-1 (last bit sampled) -> go IDLE.
  - On that transition, if latched addr < CHANNELS:
    - data_out <= assembled word;
    - chan_out <= addr;
    - data_valid pulses;
    - shadow[addr] <= word;
    - ovf[addr] <= ovf_global_in;
    - rtc_ovf |= ovf_rtc_in.
  - On that transition, if addr >= CHANNELS: word discarded, frame_err pulses, data_out/shadow unchanged.
- sl_in=1 during SHIFT, including the last-bit cycle: current frame aborted; frame_err pulses; no data_valid, no shadow write. Treated as a new load: address relatched, counter=0, stays SHIFT.
- sl_in=1 in the cycle data_valid is high (IDLE) is a legal back-to-back load.
- data_out/chan_out hold until the next valid word.
- rd_data/rd_ovf reflect a shadow write from the cycle after the write. No read/write collision hazard exists: the read is combinational from registers.
- Bit counter width is clog2(WIDTH); no wrap occurs, since it is reset on every load.
- Reset asserted mid-frame: frame dropped silently (no frame_err), IDLE next cycle.

## Timing
- Load sampled at cycle L.
- Data bits sampled at L+1 .. L+WIDTH (MSB at L+1).
- data_valid, data_out, chan_out, shadow update visible at L+WIDTH+1.
- busy high L+1 .. L+WIDTH.
- Minimum frame period WIDTH+1 cycles.
- frame_err registered: high exactly one cycle after the offending sl_in, or at L+WIDTH+1 for a bad address.

## Test plan
- Reset, then sl_in pulse with addr_in=3, serial 0xA5C3 MSB first -> data_valid at L+17; data_out=0xA5C3, chan_out=3; rd_sel=3 gives rd_data=0xA5C3, rd_ovf=0.
- Eight back-to-back frames, channels 0..7, value 0x1000+ch, ovf_global_in=1 on ch5 last bit only -> eight data_valid pulses 17 cycles apart; all shadows correct; only rd_ovf for ch5 = 1.
- sl_in reasserted at 8th data bit (addr 2 -> 6) -> frame_err one cycle; no data_valid for ch2; ch6 word completes 17 cycles after second load.
- addr_in=9 frame of 0xFFFF -> frame_err at L+17; data_valid stays 0; all shadows unchanged.
- ovf_rtc_in=1 on last bit of one frame, 0 afterwards -> rtc_ovf stays 1 through later frames until reset.
- reset asserted at bit 10 of a frame -> all outputs 0 next cycle, no pulses; next frame received correctly.
